// File: rtl/waterlight_sequencer_pkg.sv
// waterlight_pkg: shared mode constants, speed floor and sequencer state type
package waterlight_pkg;
  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_1 = 2'b01;
  localparam logic [1:0] MODE_2 = 2'b10;
  localparam logic [1:0] MODE_3 = 2'b11;
  localparam int SPEED_MIN = 2;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/waterlight_sequencer_if.sv
// waterlight_sequencer_if: bridge-side table/control bus plus the WaterLight drive and status lines
interface waterlight_sequencer_if #(parameter int STEPS = 8, parameter int SPEED_W = 32, parameter int REP_W = 8);
  localparam int AW = $clog2(STEPS);
  logic cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [1:0] cfg_mode;
  logic [SPEED_W-1:0] cfg_speed;
  logic [REP_W-1:0] cfg_repeat;
  logic [AW:0] num_steps;
  logic loop_en;
  logic ctrl_start;
  logic ctrl_stop;
  logic [1:0] WaterLight_mode;
  logic [SPEED_W-1:0] WaterLight_speed;
  logic busy;
  logic [AW-1:0] step_idx;
  logic done;
  logic cfg_err;
  modport master(output cfg_we, cfg_addr, cfg_mode, cfg_speed, cfg_repeat, num_steps, loop_en, ctrl_start, ctrl_stop,
                 input WaterLight_mode, WaterLight_speed, busy, step_idx, done, cfg_err);
  modport slave(input cfg_we, cfg_addr, cfg_mode, cfg_speed, cfg_repeat, num_steps, loop_en, ctrl_start, ctrl_stop,
                output WaterLight_mode, WaterLight_speed, busy, step_idx, done, cfg_err);
endinterface

// File: rtl/waterlight_sequencer_step_ram.sv
// waterlight_step_ram: step table with a speed-floor write check and two async read ports
module waterlight_step_ram import waterlight_pkg::*; #(
  parameter int STEPS = 8,
  parameter int SPEED_W = 32,
  parameter int REP_W = 8,
  localparam int AW = $clog2(STEPS)
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               we,
  input  logic [AW-1:0]      wr_addr,
  input  logic [1:0]         wr_mode,
  input  logic [SPEED_W-1:0] wr_speed,
  input  logic [REP_W-1:0]   wr_repeat,
  input  logic [AW-1:0]      rd_addr,
  output logic [1:0]         rd0_mode,
  output logic [SPEED_W-1:0] rd0_speed,
  output logic [REP_W-1:0]   rd0_repeat,
  output logic [1:0]         rd1_mode,
  output logic [SPEED_W-1:0] rd1_speed,
  output logic [REP_W-1:0]   rd1_repeat,
  output logic               wr_err
);
  logic [1:0] mode_q [STEPS];
  logic [SPEED_W-1:0] speed_q [STEPS];
  logic [REP_W-1:0] rep_q [STEPS];
  logic ok;
  assign ok = wr_speed >= SPEED_W'(SPEED_MIN);
  // Speeds below the floor would let WaterLight's counter overrun its compare, so such writes are dropped and flagged
  always_ff @(posedge clk)
    if (RST) begin
      for (int i = 0; i < STEPS; i++) begin
        mode_q[i] <= MODE_OFF;
        speed_q[i] <= SPEED_W'(SPEED_MIN);
        rep_q[i] <= REP_W'(1);
      end
      wr_err <= 1'b0;
    end else begin
      wr_err <= we & ~ok;
      if (we & ok) begin
        mode_q[wr_addr] <= wr_mode;
        speed_q[wr_addr] <= wr_speed;
        rep_q[wr_addr] <= wr_repeat;
      end
    end
  assign rd0_mode = mode_q[0];
  assign rd0_speed = speed_q[0];
  assign rd0_repeat = rep_q[0];
  assign rd1_mode = mode_q[rd_addr];
  assign rd1_speed = speed_q[rd_addr];
  assign rd1_repeat = rep_q[rd_addr];
endmodule

// File: rtl/waterlight_sequencer.sv
// waterlight_sequencer: plays a table of (mode, speed, repeat) steps into WaterLight, paced by LEDclk rises
module waterlight_sequencer import waterlight_pkg::*; #(
  parameter int STEPS = 8,
  parameter int SPEED_W = 32,
  parameter int REP_W = 8
) (
  input logic clk,
  input logic RST,
  input logic LEDclk,
  waterlight_sequencer_if.slave bus
);
  localparam int AW = $clog2(STEPS);
  state_t state;
  logic ledclk_q, rise, loop_q, start_ok, at_last, start_err, ram_err;
  logic [AW:0] num_q;
  logic [AW-1:0] nxt_idx;
  logic [REP_W-1:0] rep_cnt, rep0, rep1, ram_rep0, ram_rep1;
  logic [1:0] mode0, mode1;
  logic [SPEED_W-1:0] speed0, speed1;
  waterlight_step_ram #(.STEPS(STEPS), .SPEED_W(SPEED_W), .REP_W(REP_W)) u_ram (
    .clk(clk), .RST(RST), .we(bus.cfg_we), .wr_addr(bus.cfg_addr), .wr_mode(bus.cfg_mode),
    .wr_speed(bus.cfg_speed), .wr_repeat(bus.cfg_repeat), .rd_addr(nxt_idx),
    .rd0_mode(mode0), .rd0_speed(speed0), .rd0_repeat(ram_rep0),
    .rd1_mode(mode1), .rd1_speed(speed1), .rd1_repeat(ram_rep1), .wr_err(ram_err)
  );
  assign rise = LEDclk & ~ledclk_q;
  assign at_last = {1'b0, bus.step_idx} == num_q - 1'b1;
  assign nxt_idx = at_last ? '0 : bus.step_idx + 1'b1;
  assign rep0 = ram_rep0 == '0 ? REP_W'(1) : ram_rep0;
  assign rep1 = ram_rep1 == '0 ? REP_W'(1) : ram_rep1;
  assign start_ok = bus.ctrl_start & ~bus.ctrl_stop & (bus.num_steps != '0) & (bus.num_steps <= (AW+1)'(STEPS));
  assign bus.cfg_err = ram_err | start_err;
  // Sequencer FSM: stop beats everything, start loads step 0, each LEDclk rise counts down the current step
  always_ff @(posedge clk)
    if (RST) begin
      state <= IDLE;
      ledclk_q <= 1'b0;
      rep_cnt <= '0;
      num_q <= '0;
      loop_q <= 1'b0;
      start_err <= 1'b0;
      bus.WaterLight_mode <= MODE_OFF;
      bus.WaterLight_speed <= SPEED_W'(SPEED_MIN);
      bus.busy <= 1'b0;
      bus.step_idx <= '0;
      bus.done <= 1'b0;
    end else begin
      ledclk_q <= LEDclk;
      bus.done <= 1'b0;
      start_err <= 1'b0;
      if (bus.ctrl_stop) begin
        state <= IDLE;
        bus.WaterLight_mode <= MODE_OFF;
        bus.busy <= 1'b0;
        bus.step_idx <= '0;
      end else if (state == IDLE) begin
        if (start_ok) begin
          state <= RUN;
          bus.WaterLight_mode <= mode0;
          bus.WaterLight_speed <= speed0;
          rep_cnt <= rep0;
          bus.step_idx <= '0;
          bus.busy <= 1'b1;
          num_q <= bus.num_steps;
          loop_q <= bus.loop_en;
        end else start_err <= bus.ctrl_start;
      end else if (rise) begin
        if (rep_cnt > REP_W'(1)) rep_cnt <= rep_cnt - 1'b1;
        else if (at_last & ~loop_q) begin
          state <= IDLE;
          bus.WaterLight_mode <= MODE_OFF;
          bus.busy <= 1'b0;
          bus.step_idx <= '0;
          bus.done <= 1'b1;
        end else begin
          bus.step_idx <= nxt_idx;
          bus.WaterLight_mode <= mode1;
          bus.WaterLight_speed <= speed1;
          rep_cnt <= rep1;
        end
      end
    end
endmodule

// File: tb/tb_waterlight_sequencer.sv
// tb_waterlight_sequencer: scoreboard bench with a WaterLight LEDclk model and a step-level reference
module tb_waterlight_sequencer;
  import waterlight_pkg::*;
  localparam int STEPS = 8, SPEED_W = 32, REP_W = 8;
  typedef struct {logic [1:0] m; logic [31:0] s; logic b; logic [2:0] i; logic d; logic e; int rc;} ev_t;
  logic clk = 0, RST = 1, LEDclk;
  logic model_en = 1, man_req = 0, man_led = 0, wl_led = 0, mon_en = 0;
  logic [31:0] wl_cnt = 0;
  logic [1:0] tm [STEPS];
  logic [31:0] ts [STEPS];
  logic [7:0] tr [STEPS];
  logic [1:0] cur_m = 0;
  logic [31:0] cur_s = 2;
  ev_t q[$];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  waterlight_sequencer_if #(.STEPS(STEPS), .SPEED_W(SPEED_W), .REP_W(REP_W)) bus();
  waterlight_sequencer #(.STEPS(STEPS), .SPEED_W(SPEED_W), .REP_W(REP_W)) dut (.clk(clk), .RST(RST), .LEDclk(LEDclk), .bus(bus));
  // WaterLight stand-in: LEDclk toggles every 'speed' cycles; manual source is registered the same way
  always @(posedge clk) begin
    man_led <= man_req;
    if (RST) begin
      wl_cnt <= 0;
      wl_led <= 0;
    end else if (wl_cnt >= bus.WaterLight_speed - 1) begin
      wl_cnt <= 0;
      wl_led <= ~wl_led;
    end else wl_cnt <= wl_cnt + 1;
  end
  assign LEDclk = model_en ? wl_led : man_led;
  // Monitor: every output change, done or cfg_err pulse is an event matched against the queue head
  initial begin
    logic [1:0] pm;
    logic [31:0] ps;
    logic pb, lp;
    logic [2:0] pi;
    int rc;
    ev_t x;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        pm = 0; ps = 2; pb = 0; pi = 0; rc = 0; lp = LEDclk;
      end else begin
        if ({bus.WaterLight_mode, bus.WaterLight_speed, bus.busy, bus.step_idx} != {pm, ps, pb, pi} || bus.done || bus.cfg_err) begin
          tests++;
          if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event m=%0d s=%0d b=%0b i=%0d d=%0b e=%0b", bus.WaterLight_mode, bus.WaterLight_speed, bus.busy, bus.step_idx, bus.done, bus.cfg_err);
          end else begin
            x = q.pop_front();
            if (bus.WaterLight_mode !== x.m || bus.WaterLight_speed !== x.s || bus.busy !== x.b || bus.step_idx !== x.i ||
                bus.done !== x.d || bus.cfg_err !== x.e || (x.rc >= 0 && rc != x.rc)) begin
              fails++;
              $display("FAIL event got m=%0d s=%0d b=%0b i=%0d d=%0b e=%0b rises=%0d expected m=%0d s=%0d b=%0b i=%0d d=%0b e=%0b rises=%0d",
                       bus.WaterLight_mode, bus.WaterLight_speed, bus.busy, bus.step_idx, bus.done, bus.cfg_err, rc,
                       x.m, x.s, x.b, x.i, x.d, x.e, x.rc);
            end
          end
          pm = bus.WaterLight_mode; ps = bus.WaterLight_speed; pb = bus.busy; pi = bus.step_idx; rc = 0;
        end
        if (LEDclk && !lp) rc++;
        lp = LEDclk;
      end
    end
  end
  function automatic int rep1(logic [7:0] r);
    return r == 0 ? 1 : int'(r);
  endfunction
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic push(logic [1:0] m, logic [31:0] s, logic b, int i, logic d, logic e, int rc);
    ev_t x;
    x.m = m; x.s = s; x.b = b; x.i = 3'(i); x.d = d; x.e = e; x.rc = rc;
    q.push_back(x);
    cur_m = m;
    cur_s = s;
  endtask
  task automatic drain(int budget);
    int k = 0;
    while (q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout pending=%0d required=0", q.size());
      q.delete();
    end
  endtask
  task automatic wr(int a, logic [1:0] m, logic [31:0] s, logic [7:0] r);
    bus.cfg_we = 1; bus.cfg_addr = 3'(a); bus.cfg_mode = m; bus.cfg_speed = s; bus.cfg_repeat = r;
    if (s >= 2) begin
      tm[a] = m; ts[a] = s; tr[a] = r;
    end else push(cur_m, cur_s, 0, 0, 0, 1, -1);
    tick();
    bus.cfg_we = 0;
  endtask
  task automatic start(int n, logic lp);
    bus.num_steps = 4'(n); bus.loop_en = lp; bus.ctrl_start = 1;
    tick();
    bus.ctrl_start = 0;
  endtask
  task automatic stop_now();
    push(0, cur_s, 0, 0, 0, 0, -1);
    bus.ctrl_stop = 1;
    tick();
    bus.ctrl_stop = 0;
    chk("stop_mode", bus.WaterLight_mode, 0);
    chk("stop_busy", bus.busy, 0);
  endtask
  task automatic run_prog(int n, logic lp, int passes);
    push(tm[0], ts[0], 1, 0, 0, 0, -1);
    start(n, lp);
    for (int k = 1; k <= (lp ? passes * n : n - 1); k++) push(tm[k % n], ts[k % n], 1, k % n, 0, 0, rep1(tr[(k - 1) % n]));
    if (!lp) push(0, ts[n - 1], 0, 0, 1, 0, rep1(tr[n - 1]));
    drain(4000);
    if (lp) stop_now();
  endtask
  task automatic reset_table();
    for (int a = 0; a < STEPS; a++) begin
      tm[a] = 0; ts[a] = 2; tr[a] = 1;
    end
    cur_m = 0;
    cur_s = 2;
  endtask
  initial begin
    int n, bad;
    logic lp;
    bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_mode = 0; bus.cfg_speed = 2; bus.cfg_repeat = 1;
    bus.num_steps = 0; bus.loop_en = 0; bus.ctrl_start = 0; bus.ctrl_stop = 0;
    reset_table();
    repeat (3) tick();
    RST = 0;
    mon_en = 1;
    repeat (20) tick();
    chk("rst_mode", bus.WaterLight_mode, 0);
    chk("rst_speed", bus.WaterLight_speed, 2);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.cfg_err, 0);
    chk("rst_idx", bus.step_idx, 0);
    wr(0, 1, 4, 2); wr(1, 2, 6, 1); wr(2, 3, 3, 3);
    run_prog(3, 0, 1);
    run_prog(3, 1, 2);
    wr(0, 1, 1, 5);
    run_prog(1, 0, 1);
    push(cur_m, cur_s, 0, 0, 0, 1, -1);
    start(0, 0);
    push(cur_m, cur_s, 0, 0, 0, 1, -1);
    start(9, 0);
    drain(10);
    chk("bad_start_busy", bus.busy, 0);
    bus.num_steps = 3; bus.ctrl_start = 1; bus.ctrl_stop = 1;
    tick();
    bus.ctrl_start = 0; bus.ctrl_stop = 0;
    repeat (5) tick();
    chk("start_stop_busy", bus.busy, 0);
    chk("start_stop_mode", bus.WaterLight_mode, 0);
    wr(0, 1, 2, 0); wr(1, 2, 3, 2);
    run_prog(2, 0, 1);
    model_en = 0;
    wr(0, 1, 5, 1); wr(1, 3, 7, 1);
    push(tm[0], ts[0], 1, 0, 0, 0, -1);
    start(2, 0);
    push(3, 7, 1, 1, 0, 0, 1);
    man_req = 1; tick(); man_req = 0; tick();
    drain(20);
    man_req = 1; tick();
    push(0, 7, 0, 0, 0, 0, -1);
    bus.ctrl_stop = 1; tick();
    bus.ctrl_stop = 0; man_req = 0;
    repeat (4) tick();
    drain(5);
    chk("coincident_stop_busy", bus.busy, 0);
    model_en = 1;
    wr(0, 2, 3, 2); wr(1, 1, 4, 1); wr(2, 3, 5, 2);
    push(tm[0], ts[0], 1, 0, 0, 0, -1);
    start(3, 1);
    push(tm[1], ts[1], 1, 1, 0, 0, 2);
    drain(200);
    mon_en = 0;
    q.delete();
    RST = 1;
    tick();
    chk("midrst_mode", bus.WaterLight_mode, 0);
    chk("midrst_speed", bus.WaterLight_speed, 2);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_idx", bus.step_idx, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_err", bus.cfg_err, 0);
    RST = 0;
    reset_table();
    mon_en = 1;
    tick();
    run_prog(1, 0, 1);
    for (int t = 0; t < 20; t++) begin
      n = $urandom_range(1, 8);
      lp = (n > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      for (int a = 0; a < n; a++) wr(a, 2'($urandom_range(0, 3)), $urandom_range(2, 7), 8'($urandom_range(0, 4)));
      if ($urandom_range(0, 3) == 0) wr($urandom_range(0, 7), 2'($urandom_range(0, 3)), $urandom_range(0, 1), 8'(3));
      if ($urandom_range(0, 3) == 0) begin
        bad = $urandom_range(0, 1) ? 0 : $urandom_range(9, 15);
        push(cur_m, cur_s, 0, 0, 0, 1, -1);
        start(bad, 0);
        drain(5);
      end
      run_prog(n, lp, 2);
    end
    repeat (5) tick();
    drain(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
